// File: rtl/muldiv_pkg.sv
// Shared constants and types for the sequential RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned XLEN    = 32;
  // Edges from start acceptance (inclusive) to the DONE cycle: PREP + 32 CALC + FIX + DONE.
  localparam int unsigned LATENCY = 35;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_CALC = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

endpackage

// File: rtl/muldiv_datapath.sv
// Operand latches, shift-add multiplier / restoring divider and sign fix-up.
module muldiv_datapath
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = muldiv_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            prep,
  input  logic            calc,
  input  logic            fix,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result
);

  op_e             op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] mcand_q, mcand_d;   // multiplicand magnitude, or divisor magnitude
  logic [XLEN-1:0] hi_q, hi_d;         // product high word, or partial remainder
  logic [XLEN-1:0] lo_q, lo_d;         // product low word / multiplier, or dividend/quotient
  logic            neg_q, neg_d;       // negate product or quotient in FIX
  logic            rneg_q, rneg_d;     // negate remainder in FIX
  logic [XLEN-1:0] result_q, result_d;

  logic              is_div;
  logic              a_signed, b_signed;
  logic              sa, sb;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic              b_zero;
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     shifted;
  logic              ge;
  logic [XLEN-1:0]   diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  // Next-state for operands, iteration registers and result.
  always_comb begin
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    mcand_d  = mcand_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    is_div   = op_q[2];
    a_signed = op_q inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op_q inside {OP_MULH, OP_DIV, OP_REM};
    sa       = a_signed & a_q[XLEN-1];
    sb       = b_signed & b_q[XLEN-1];
    a_mag    = sa ? -a_q : a_q;
    b_mag    = sb ? -b_q : b_q;
    b_zero   = (b_q == '0);

    mul_sum  = {1'b0, hi_q} + {1'b0, (lo_q[0] ? mcand_q : '0)};
    shifted  = {hi_q, lo_q[XLEN-1]};
    ge       = (shifted >= {1'b0, mcand_q});
    diff     = shifted[XLEN-1:0] - mcand_q;

    prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = rneg_q ? -hi_q : hi_q;

    if (load) begin
      op_d = op_e'(f3);
      a_d  = a;
      b_d  = b;
    end

    if (prep) begin
      hi_d = '0;
      if (is_div) begin
        lo_d    = a_mag;
        mcand_d = b_mag;
        // Divide by zero yields all-ones quotient unsigned; skip negation so signed DIV matches.
        neg_d   = (sa ^ sb) & ~b_zero;
        rneg_d  = sa;
      end else begin
        lo_d    = b_mag;
        mcand_d = a_mag;
        neg_d   = sa ^ sb;
        rneg_d  = 1'b0;
      end
    end

    if (calc) begin
      if (is_div) begin
        hi_d = ge ? diff : shifted[XLEN-1:0];
        lo_d = {lo_q[XLEN-2:0], ge};
      end else begin
        hi_d = mul_sum[XLEN:1];
        lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end

    if (fix) begin
      unique case (op_q)
        OP_MUL:                      result_d = prod_fix[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: result_d = prod_fix[2*XLEN-1:XLEN];
        OP_DIV, OP_DIVU:             result_d = quo_fix;
        default:                     result_d = rem_fix;
      endcase
    end
  end

  // Datapath registers; reset clears operands and result immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      mcand_q  <= mcand_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule

// File: rtl/muldiv_seq.sv
// Sequential RV32M multiply/divide: control FSM and iteration counter.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN        = muldiv_pkg::XLEN,
  parameter int unsigned CALC_CYCLES = XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      f3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CNT_W = $clog2(CALC_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CALC_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load, prep, calc, fix;

  // Next-state, counter and datapath strobes.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    prep    = 1'b0;
    calc    = 1'b0;
    fix     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_PREP;
        end
      end
      ST_PREP: begin
        prep    = 1'b1;
        cnt_d   = '0;
        state_d = ST_CALC;
      end
      ST_CALC: begin
        calc  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) state_d = ST_FIX;
      end
      ST_FIX: begin
        fix     = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

  muldiv_datapath #(
    .XLEN(XLEN)
  ) u_datapath (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .prep  (prep),
    .calc  (calc),
    .fix   (fix),
    .f3    (f3),
    .a     (a),
    .b     (b),
    .result(result)
  );

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M vectors with hand-computed results.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  f3;
  logic [31:0] a, b;
  logic        busy, done;
  logic [31:0] result;

  muldiv_seq #(
    .XLEN       (32),
    .CALC_CYCLES(32)
  ) dut (
    .clk   (clk),
    .rst   (rst_n),
    .start (start),
    .f3    (f3),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [31:0] exp;
    string       name;
    int          issue;
  } exp_t;

  exp_t sb_q[$];
  int tests = 0, fails = 0, done_seen = 0, done_expected = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Monitor: every done pulse pops one expectation and checks result and latency.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && done) begin
      done_seen++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done with result %h expected no done pulse", result);
      end else begin
        e = sb_q.pop_front();
        check({e.name, "_result"}, result, e.exp);
        check({e.name, "_latency"}, 32'(cyc - e.issue), 32'd35);
      end
    end
  end

  task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] aa,
                        input logic [31:0] bb, input logic [31:0] exp,
                        input int glitch_at, input bit start_in_done);
    int n;
    bit busy_ok, got;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    f3    = op;
    a     = aa;
    b     = bb;
    start = 1'b1;
    sb_q.push_back('{exp, nm, cyc});
    done_expected++;
    @(negedge clk);
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    f3    = 3'($urandom);
    busy_ok = 1'b1;
    got     = 1'b0;
    n       = 1;
    while (!got && n < 60) begin
      if (done) got = 1'b1;
      else begin
        if (!busy) busy_ok = 1'b0;
        if (n == glitch_at) begin
          start = 1'b1;
          f3    = 3'b000;
          a     = 32'h0000_0055;
          b     = 32'h0000_0003;
        end else start = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check({nm, "_done_seen"}, 32'(got), 32'd1);
    check({nm, "_busy_held"}, 32'(busy_ok), 32'd1);
    if (!got) begin
      sb_q.pop_back();
      done_expected--;
    end
    if (start_in_done && got) begin
      start = 1'b1;
      f3    = 3'b000;
      a     = 32'd9;
      b     = 32'd9;
      @(negedge clk);
      start = 1'b0;
      check({nm, "_start_in_done_ignored"}, 32'(busy), 32'd0);
    end else begin
      @(negedge clk);
    end
    check({nm, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    f3    = '0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("mul_7_m3",      3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 0, 0);
    run_op("mulhu_ff_ff",   3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0, 0);
    run_op("mulh_ff_ff",    3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    run_op("mulhsu_ff_2",   3'b010, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 0, 0);
    run_op("mulh_min_min",  3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0, 0);
    run_op("mul_shift",     3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 0, 1);
    run_op("div_m7_2",      3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0, 0);
    run_op("rem_m7_2",      3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0, 0);
    run_op("div_7_m2",      3'b100, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 0, 0);
    run_op("rem_7_m2",      3'b110, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 0, 0);
    run_op("divu_100_7",    3'b101, 32'd100,       32'd7,         32'd14,        0, 0);
    run_op("remu_100_7",    3'b111, 32'd100,       32'd7,         32'd2,         0, 0);
    run_op("div_by_zero",   3'b100, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 0, 0);
    run_op("divu_by_zero",  3'b101, 32'h0000_1234, 32'd0,         32'hFFFF_FFFF, 0, 0);
    run_op("rem_by_zero",   3'b110, 32'h0000_1234, 32'd0,         32'h0000_1234, 0, 0);
    run_op("remu_by_zero",  3'b111, 32'h0000_1234, 32'd0,         32'h0000_1234, 0, 0);
    run_op("div_neg_by_0",  3'b100, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF, 0, 0);
    run_op("rem_neg_by_0",  3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0, 0);
    run_op("div_overflow",  3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0, 0);
    run_op("rem_overflow",  3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0, 0);
    run_op("mul_restart",   3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 10, 0);

    // Abort a divide midway through CALC with a reset pulse between clock edges.
    f3    = 3'b101;
    a     = 32'd100;
    b     = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    #4 rst_n = 1'b1;
    @(negedge clk);
    check("abort_idle_after", 32'(busy), 32'd0);
    repeat (45) @(negedge clk);

    run_op("divu_after_rst", 3'b101, 32'd100, 32'd7, 32'd14, 0, 0);
    run_op("rem_after_rst",  3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 0, 0);

    repeat (3) @(negedge clk);
    check("done_pulse_count", 32'(done_seen), 32'(done_expected));
    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard stop so the run always ends even if the stimulus stalls.
  initial begin
    #200000;
    $display("FAIL global_timeout: got simulation still running expected finish");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "timeout");
  end

endmodule
